seq_mult_param: RTL
===================

Name: seq_mult_param

Overview:
Parametrised sequential shift-add multiplier. It is the successor to the fixed-width one-hot binary multiplier, adding a generic operand WIDTH, runtime signed/unsigned mode and a done pulse. A one-hot controller drives a datapath of B, A (WIDTH+1 bits), Q, a Booth bit Q_1 and a down-counter P. It runs one multiplication at a time under a start/rdy handshake.

Parameters:
WIDTH, 8, operand width in bits (legal values >= 2); product is 2*WIDTH bits.
CNT_W, $clog2(WIDTH+1), derived localparam; width of iteration counter P (not overridable).

Ports:
clk  input  1  system clock, rising edge.
rst_b  input  1  asynchronous active-low reset.
start  input  1  request; sampled only while in S_IDLE.
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands.
multiplicand  input  WIDTH  operand loaded into B.
multiplier  input  WIDTH  operand loaded into Q.
product  output  2*WIDTH  result; valid and stable while rdy=1.
rdy  output  1  1 in S_IDLE (ready / result valid), 0 while busy.
done  output  1  one-cycle pulse on the first cycle rdy returns high after an operation.

Behaviour:
- Reset (async, rst_b=0): state=S_IDLE, product=0, rdy=1, done=0, A=Q=B=P=Q_1=0, mode register=0. Reset mid-operation aborts it; no done pulse.
- State register is one-hot, three states:
  - S_IDLE: rdy=1.
  - S_ADD: rdy=0.
  - S_SHIFT: rdy=0.
- S_IDLE with start=1 at edge k:
  - Load B=multiplicand, Q=multiplier, A=0, Q_1=0, P=WIDTH; latch signed_mode.
  - Go to S_ADD. rdy=0 from edge k.
- S_ADD, unsigned mode: if Q[0]=1 then A = {0,A[WIDTH-1:0]} + {0,B}; A[WIDTH] acts as carry C. Otherwise A is held.
- S_ADD, signed mode (radix-2 Booth on {Q[0],Q_1}), with B sign-extended to WIDTH+1 bits:
  - 10: A = A - B.
  - 01: A = A + B.
  - 00 or 11: A held.
- S_ADD always: P decrements by 1; next state is S_SHIFT.
- S_SHIFT, unsigned mode: logical right shift of {A,Q}, zero fill at MSB.
- S_SHIFT, signed mode: arithmetic right shift of {A,Q,Q_1}, A[WIDTH] replicated.
- S_SHIFT exit: if P==0, go to S_IDLE and load product={A[WIDTH-1:0],Q} from the post-shift values; otherwise go to S_ADD.
- Latency: exactly 2*WIDTH busy cycles. For start accepted at edge k, rdy=1, done=1 and product updates at edge k+2*WIDTH. done falls at the following edge.
- start while busy is ignored. start held high in S_IDLE starts a new operation on the cycle after done, i.e. back-to-back operation.
- product holds its value through the next operation until that operation completes; it is not cleared at start.
- Operands may change freely after the start edge.
- Widths: A is WIDTH+1 bits, so no intermediate overflow occurs, including signed B = -2^(WIDTH-1).
- Result: product equals the exact 2*WIDTH-bit product in the selected mode.

Optional Feature:
Macro: SEQ_MULT_ZERO_BYPASS_EN.
- Defined:
  - In S_IDLE with start=1 and (multiplicand==0 or multiplier==0), the FSM stays in S_IDLE.
  - product<=0 at that edge, rdy stays 1, done pulses for one cycle.
  - Latency 1 cycle; no other state is entered.
- Undefined: zero operands take the normal 2*WIDTH-cycle path, and the result is 0.

Test Plan:
1. WIDTH=8, unsigned, 255*255, start at edge k -> rdy=0 for cycles k..k+15; at k+16 product=16'hFE01, rdy=1, done=1 for one cycle.
2. WIDTH=8, signed, -128*-128 (8'h80, 8'h80) -> product=16'h4000. Also signed -1*127 -> 16'hFF81. Also unsigned 8'h80*8'h80 -> 16'h4000 and 8'hFF*8'h7F -> 16'h7E81.
3. Exhaustive WIDTH=4, both modes, all 256 pairs back-to-back with start held high -> every product matches the reference model; done count = 512; each operation takes 8 busy cycles.
4. start pulsed high at busy cycles 3 and 10 of an operation with new operands -> ignored; product equals the first operation's result at cycle 16.
5. rst_b low for one cycle at busy cycle 7 -> immediately rdy=1, product=0, done=0. A following start on 3*5 unsigned gives product=15 after 16 cycles.
6. Zero-operand start, unsigned 0*200:
   - with SEQ_MULT_ZERO_BYPASS_EN defined -> product=0 and done=1 at the next edge, rdy never drops;
   - without the macro -> rdy low for 16 cycles, then product=0.

Source files
------------

// File: rtl/seq_mult_param_if.sv
// Start/ready handshake and operand/result bundle for seq_mult_param.
interface seq_mult_param_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
    logic [2*WIDTH-1:0]   product;
    logic                 rdy;
    logic                 done;

    modport master (
        output start, signed_mode, multiplicand, multiplier,
        input  product, rdy, done
    );

    modport slave (
        input  start, signed_mode, multiplicand, multiplier,
        output product, rdy, done
    );
endinterface

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier, unsigned or radix-2 Booth signed, 2*WIDTH busy cycles.
// Optional SEQ_MULT_ZERO_BYPASS_EN: a zero operand completes in one cycle without leaving S_IDLE.
module seq_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_b,
    seq_mult_param_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'b001,
        S_ADD   = 3'b010,
        S_SHIFT = 3'b100
    } state_t;

    state_t               state_r;
    logic [WIDTH:0]       a_r;
    logic [WIDTH-1:0]     q_r;
    logic [WIDTH-1:0]     b_r;
    logic                 q1_r;
    logic [CNT_W-1:0]     p_r;
    logic                 mode_r;
    logic [2*WIDTH-1:0]   product_r;
    logic                 rdy_r;
    logic                 done_r;

    logic [WIDTH:0]       b_ext_s;
    logic [WIDTH:0]       add_s;
    logic [WIDTH:0]       sh_a_s;
    logic [WIDTH-1:0]     sh_q_s;
    logic                 sh_q1_s;
    logic                 bypass_s;

`ifdef SEQ_MULT_ZERO_BYPASS_EN
    assign bypass_s = (bus.multiplicand == {WIDTH{1'b0}}) || (bus.multiplier == {WIDTH{1'b0}});
`else
    assign bypass_s = 1'b0;
`endif

    // Datapath next values for the add and shift phases.
    always_comb begin
        b_ext_s = mode_r ? {b_r[WIDTH-1], b_r} : {1'b0, b_r};
        add_s   = a_r;
        if (mode_r) begin
            case ({q_r[0], q1_r})
                2'b10:   add_s = a_r - b_ext_s;
                2'b01:   add_s = a_r + b_ext_s;
                default: add_s = a_r;
            endcase
        end else begin
            if (q_r[0]) begin
                add_s = {1'b0, a_r[WIDTH-1:0]} + {1'b0, b_r};
            end else begin
                add_s = a_r;
            end
        end
        // Signed mode replicates the sign bit; unsigned shifts the carry down with zero fill.
        sh_a_s  = {(mode_r ? a_r[WIDTH] : 1'b0), a_r[WIDTH:1]};
        sh_q_s  = {a_r[0], q_r[WIDTH-1:1]};
        sh_q1_s = q_r[0];
    end

    // One-hot controller with registered datapath and outputs.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_r   <= S_IDLE;
            a_r       <= {(WIDTH+1){1'b0}};
            q_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            q1_r      <= 1'b0;
            p_r       <= {CNT_W{1'b0}};
            mode_r    <= 1'b0;
            product_r <= {(2*WIDTH){1'b0}};
            rdy_r     <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        if (bypass_s) begin
                            product_r <= {(2*WIDTH){1'b0}};
                            done_r    <= 1'b1;
                        end else begin
                            b_r     <= bus.multiplicand;
                            q_r     <= bus.multiplier;
                            a_r     <= {(WIDTH+1){1'b0}};
                            q1_r    <= 1'b0;
                            p_r     <= CNT_W'(WIDTH);
                            mode_r  <= bus.signed_mode;
                            rdy_r   <= 1'b0;
                            state_r <= S_ADD;
                        end
                    end
                end
                S_ADD: begin
                    a_r     <= add_s;
                    p_r     <= p_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    state_r <= S_SHIFT;
                end
                S_SHIFT: begin
                    a_r  <= sh_a_s;
                    q_r  <= sh_q_s;
                    q1_r <= sh_q1_s;
                    if (p_r == {CNT_W{1'b0}}) begin
                        product_r <= {sh_a_s[WIDTH-1:0], sh_q_s};
                        rdy_r     <= 1'b1;
                        done_r    <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r   <= S_ADD;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    rdy_r   <= 1'b1;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.product = product_r;
    assign bus.rdy     = rdy_r;
    assign bus.done    = done_r;
endmodule
